// File: rtl/multiplexor_display_4dig.sv
// rtl/multiplexor_display_4dig.sv - 4-digit time-multiplexed nibble feeder with frame-boundary staging
// Optional leading-zero blanking is enabled by defining MULTIPLEXOR_BLANCO_CEROS_EN.
module multiplexor_display_4dig #(
   parameter int DIV   = 50000,
   parameter int CNT_W = 20
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_dato,
   input  logic        i_cargar,
   input  logic        i_habilitar,
   output logic [3:0]  o_bits,
   output logic [3:0]  o_anodos,
   output logic        o_pendiente,
   output logic        o_frame
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [15:0]      disp;
   logic [15:0]      staging;
   logic             pendiente;
   logic             frame;
   logic             tick;
   logic             wrap;
   logic [3:0]       blanco;

   assign tick = (cnt == CNT_MAX) && i_habilitar;
   assign wrap = tick && (idx == 2'd3);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt       <= '0;
         idx       <= 2'd0;
         disp      <= 16'h0000;
         staging   <= 16'h0000;
         pendiente <= 1'b0;
         frame     <= 1'b0;
      end else begin
         if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else if (i_habilitar) begin
            cnt <= cnt + CNT_W'(1);
         end

         // A dark display or a frame boundary lets new data go straight to disp.
         if (i_cargar && (!i_habilitar || wrap)) begin
            disp      <= i_dato;
            staging   <= i_dato;
            pendiente <= 1'b0;
         end else if (wrap && pendiente) begin
            disp      <= staging;
            pendiente <= 1'b0;
         end else if (i_cargar) begin
            staging   <= i_dato;
            pendiente <= 1'b1;
         end

         frame <= wrap;
      end
   end

`ifdef MULTIPLEXOR_BLANCO_CEROS_EN
   assign blanco = {disp[15:12] == 4'h0, disp[15:8] == 8'h00, disp[15:4] == 12'h000, 1'b0};
`else
   assign blanco = 4'b0000;
`endif

   always_comb begin
      o_anodos = 4'b1111;
      if (i_rst_n && i_habilitar && !blanco[idx])
         o_anodos = ~(4'b0001 << idx);
   end

   assign o_bits      = disp[{idx, 2'b00} +: 4];
   assign o_pendiente = pendiente;
   assign o_frame     = frame;

endmodule

// File: tb/tb_multiplexor_display_4dig.sv
// tb/tb_multiplexor_display_4dig.sv - directed and random check of multiplexor_display_4dig against a slot-position model
module tb_multiplexor_display_4dig;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] dato = 16'h0000;
   logic        cargar = 1'b0;
   logic        habilitar = 1'b1;
   logic [3:0]  bits;
   logic [3:0]  anodos;
   logic        pendiente;
   logic        frame;

   int n_checks = 0;
   int n_fails  = 0;

   // Model: position in the frame counted in enabled cycles, plus shown/staged values.
   int          pos;
   logic [15:0] m_disp;
   logic [15:0] m_stag;
   logic        m_pend;
   logic        m_frame;

   multiplexor_display_4dig #(.DIV(DIV), .CNT_W(3)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_dato      (dato),
      .i_cargar    (cargar),
      .i_habilitar (habilitar),
      .o_bits      (bits),
      .o_anodos    (anodos),
      .o_pendiente (pendiente),
      .o_frame     (frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      pos = 0; m_disp = 16'h0; m_stag = 16'h0; m_pend = 1'b0; m_frame = 1'b0;
   endtask

   task automatic model_clock();
      logic w;
      w = habilitar && (pos == FRAME - 1);
      if (cargar && (!habilitar || w)) begin
         m_disp = dato; m_stag = dato; m_pend = 1'b0;
      end else if (w && m_pend) begin
         m_disp = m_stag; m_pend = 1'b0;
      end else if (cargar) begin
         m_stag = dato; m_pend = 1'b1;
      end
      if (habilitar) pos = (pos + 1) % FRAME;
      m_frame = w;
   endtask

   function automatic logic [3:0] exp_anodos();
      int  d;
      logic lit;
      d = pos / DIV;
      lit = rst_n && habilitar;
`ifdef MULTIPLEXOR_BLANCO_CEROS_EN
      if (d > 0 && (m_disp >> (4 * d)) == 16'h0) lit = 1'b0;
`endif
      return lit ? ~(4'b0001 << d) : 4'b1111;
   endfunction

   task automatic check_outputs();
      logic [15:0] nib;
      nib = (m_disp >> (4 * (pos / DIV))) & 16'h000f;
      check("bits", {12'h0, bits}, nib);
      check("anodos", {12'h0, anodos}, {12'h0, exp_anodos()});
      check("pendiente", {15'h0, pendiente}, {15'h0, m_pend});
      check("frame", {15'h0, frame}, {15'h0, m_frame});
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_clock();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      check("rst_anodos", {12'h0, anodos}, 16'h000f);
      repeat (3) step();
      rst_n = 1'b1;
      #1;
      check_outputs();
   endtask

   task automatic run_to(input int p);
      for (int i = 0; i < 2 * FRAME && pos != p; i++) step();
   endtask

   initial begin
      model_reset();
      cargar = 1'b0;
      habilitar = 1'b1;

      // Reset and first slot timing
      do_reset();
      for (int i = 0; i < DIV; i++) begin
         check("slot0_anodos", {12'h0, anodos}, 16'h000e);
         step();
      end
      check("slot1_anodos", {12'h0, anodos}, 16'h000d);

      // Scan order with 4321 loaded while dark
      do_reset();
      habilitar = 1'b0; cargar = 1'b1; dato = 16'h4321;
      step();
      habilitar = 1'b1; cargar = 1'b0;
      #1;
      check_outputs();
      for (int i = 0; i < FRAME; i++) begin
         check("scan_bits", {12'h0, bits}, 16'(i / DIV + 1));
         check("scan_anodos", {12'h0, anodos}, {12'h0, ~(4'b0001 << (i / DIV))});
         step();
      end
      check("scan_frame", {15'h0, frame}, 16'h0001);

      // Tear-free update during digit 1
      run_to(DIV);
      cargar = 1'b1; dato = 16'hABCD;
      step();
      cargar = 1'b0;
      check("tear_pend", {15'h0, pendiente}, 16'h0001);
      run_to(2 * DIV);
      check("tear_d2", {12'h0, bits}, 16'h0003);
      run_to(0);
      check("tear_d0", {12'h0, bits}, 16'h000d);
      check("tear_pend_clr", {15'h0, pendiente}, 16'h0000);

      // Load on the exact wrap edge
      run_to(FRAME - 1);
      cargar = 1'b1; dato = 16'h00F0;
      step();
      cargar = 1'b0;
      check("coll_pend", {15'h0, pendiente}, 16'h0000);
      run_to(DIV);
      check("coll_d1", {12'h0, bits}, 16'h000f);

      // Two loads in one frame, last wins
      run_to(2);
      cargar = 1'b1; dato = 16'h1111; step();
      cargar = 1'b0; step();
      cargar = 1'b1; dato = 16'h2222; step();
      cargar = 1'b0;
      run_to(0);
      check("two_loads_d0", {12'h0, bits}, 16'h0002);

      // Disable mid-slot at digit 2, cnt 1
      run_to(2 * DIV + 1);
      habilitar = 1'b0;
      #1;
      check("dis_anodos", {12'h0, anodos}, 16'h000f);
      repeat (10) step();
      habilitar = 1'b1;
      #1;
      for (int i = 0; i < DIV - 1; i++) begin
         check("resume_anodos", {12'h0, anodos}, 16'h000b);
         step();
      end
      check("resume_next", {12'h0, anodos}, 16'h0007);

      // Leading-zero patterns
      habilitar = 1'b0; cargar = 1'b1; dato = 16'h0070; step();
      habilitar = 1'b1; cargar = 1'b0;
      repeat (FRAME) step();
      habilitar = 1'b0; cargar = 1'b1; dato = 16'h0000; step();
      habilitar = 1'b1; cargar = 1'b0;
      repeat (FRAME) step();

      // Random traffic, including occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         habilitar = ($urandom_range(0, 99) < 85);
         cargar    = ($urandom_range(0, 99) < 15);
         dato      = 16'($urandom) >> (4 * $urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) do_reset();
         else step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
